// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that lets N_REQ cache requesters share one memory port.
// It handles one transaction at a time and broadcasts it for snooping in the issue cycle.
module mem_bus_arbiter #(
   parameter int N_REQ       = 2,
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_write,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          resp_valid,
   output logic [DATA_W-1:0]         resp_rdata,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      snoop_valid,
   output logic                      snoop_write,
   output logic [$clog2(N_REQ)-1:0]  snoop_src,
   output logic [ADDR_W-1:0]         snoop_addr
);

   localparam int SRC_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MEM_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state;
   logic [SRC_W-1:0] rr_ptr;
   logic [CNT_W-1:0] wait_cnt;
   logic             grant_any;
   logic [SRC_W-1:0] grant_idx;
   logic [SRC_W-1:0] cand;

   // NOTE: every variable gets a default before the scan, so no latch is inferred.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = SRC_W'((int'(rr_ptr) + i) % N_REQ);
         if (!grant_any && req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign req_ready = (state == IDLE && !reset && grant_any) ? (N_REQ'(1) << grant_idx) : '0;

   // The snoop/mem payload registers double as the latched transaction.
   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         wait_cnt    <= '0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         snoop_valid <= 1'b0;
         snoop_write <= 1'b0;
         snoop_src   <= '0;
         snoop_addr  <= '0;
         resp_valid  <= '0;
         resp_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  state       <= ISSUE;
                  rr_ptr      <= SRC_W'((int'(grant_idx) + 1) % N_REQ);
                  mem_en      <= 1'b1;
                  mem_we      <= req_write[grant_idx];
                  mem_addr    <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                  mem_wdata   <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
                  snoop_valid <= 1'b1;
                  snoop_write <= req_write[grant_idx];
                  snoop_src   <= grant_idx;
                  snoop_addr  <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
               end
            end
            ISSUE: begin
               mem_en      <= 1'b0;
               mem_we      <= 1'b0;
               snoop_valid <= 1'b0;
               wait_cnt    <= '0;
               state       <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == CNT_W'(MEM_LATENCY - 1)) begin
                  wait_cnt   <= '0;
                  state      <= RESP;
                  resp_valid <= N_REQ'(1) << snoop_src;
                  resp_rdata <= snoop_write ? '0 : mem_rdata;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               resp_valid <= '0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic.
// Expected values come from a transaction-level model of the arbitration and timing rules.
module tb_mem_bus_arbiter;

   localparam int N  = 2;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int L  = 2;
   localparam int SW = 1;

   typedef struct packed {
      logic [SW-1:0] src;
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
   } txn_t;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_write;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    resp_valid;
   logic [DW-1:0]   resp_rdata;
   logic            mem_en;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;
   logic            snoop_valid;
   logic            snoop_write;
   logic [SW-1:0]   snoop_src;
   logic [AW-1:0]   snoop_addr;

   mem_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .snoop_valid(snoop_valid), .snoop_write(snoop_write), .snoop_src(snoop_src),
      .snoop_addr(snoop_addr)
   );

   always #5 clk = ~clk;

   // Memory: read data is valid only in the L-th cycle after mem_en, garbage otherwise.
   logic [DW-1:0] mem     [256];
   logic [DW-1:0] ref_mem [256];
   int            mcyc     = 0;
   int            pend_cyc = -100;
   logic [AW-1:0] pend_a   = '0;

   always @(posedge clk) mcyc++;

   always @(negedge clk) begin
      if (mem_en === 1'b1 && mem_we === 1'b1) mem[mem_addr] = mem_wdata;
      if (mem_en === 1'b1 && mem_we === 1'b0) begin
         pend_cyc = mcyc;
         pend_a   = mem_addr;
      end
      mem_rdata = (mcyc == pend_cyc + L) ? mem[pend_a] : $urandom;
   end

   // Requester agents, model state and observation logs.
   bit            ag_pend [N];
   logic          ag_wr   [N];
   logic [AW-1:0] ag_addr [N];
   logic [DW-1:0] ag_wd   [N];

   txn_t cur;
   bit   have_txn, in_rst, rearm;
   int   t_acc, rr, k, inj_pct, ka;
   int   n_vec = 0;
   int   n_bad = 0;

   int            g_src[$], g_cyc[$], r_cyc[$], en_q[$], s_src[$];
   logic [N-1:0]  r_vec[$];
   logic [DW-1:0] r_dat[$];
   bit            s_wr[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, k);
      end
   endtask

   task automatic post(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      ag_pend[i] = 1'b1;
      ag_wr[i]   = wr;
      ag_addr[i] = a;
      ag_wd[i]   = wd;
   endtask

   // One clock cycle: drive, check at the falling edge, update the model.
   task automatic step();
      logic [N-1:0] exp_ready, exp_resp;
      bit           accept, en_now, idle;
      int           win;
      for (int i = 0; i < N; i++) begin
         req_valid[i]          = ag_pend[i];
         req_write[i]          = ag_wr[i];
         req_addr[i*AW +: AW]  = ag_addr[i];
         req_wdata[i*DW +: DW] = ag_wd[i];
      end
      @(negedge clk);
      en_now   = have_txn && (k == t_acc + 1);
      exp_resp = (have_txn && k == t_acc + 2 + L) ? (N'(1) << cur.src) : '0;
      idle     = !have_txn || (k >= t_acc + 3 + L);
      accept   = 1'b0;
      win      = 0;
      if (idle && !reset)
         for (int i = 0; i < N; i++)
            if (!accept && ag_pend[(rr + i) % N]) begin
               accept = 1'b1;
               win    = (rr + i) % N;
            end
      exp_ready = accept ? (N'(1) << win) : '0;

      check("req_ready",   req_ready,   exp_ready);
      check("mem_en",      mem_en,      en_now);
      check("mem_we",      mem_we,      en_now && cur.write);
      check("mem_addr",    mem_addr,    cur.addr);
      check("mem_wdata",   mem_wdata,   cur.wdata);
      check("snoop_valid", snoop_valid, en_now);
      check("snoop_write", snoop_write, cur.write);
      check("snoop_src",   snoop_src,   cur.src);
      check("snoop_addr",  snoop_addr,  cur.addr);
      check("resp_valid",  resp_valid,  exp_resp);
      if (in_rst) check("resp_rdata_rst", resp_rdata, 0);
      else if (exp_resp != 0) check("resp_rdata", resp_rdata, cur.rdata);

      for (int i = 0; i < N; i++)
         if (req_valid[i] && req_ready[i] === 1'b1) begin
            g_src.push_back(i);
            g_cyc.push_back(k);
         end
      if (resp_valid !== '0) begin
         r_vec.push_back(resp_valid);
         r_dat.push_back(resp_rdata);
         r_cyc.push_back(k);
      end
      if (mem_en === 1'b1) en_q.push_back(k);
      if (snoop_valid === 1'b1) begin
         s_wr.push_back(snoop_write);
         s_src.push_back(int'(snoop_src));
      end

      if (reset) begin
         have_txn = 1'b0;
         cur      = '0;
         rr       = 0;
      end else if (accept) begin
         have_txn  = 1'b1;
         t_acc     = k;
         cur.src   = SW'(win);
         cur.write = ag_wr[win];
         cur.addr  = ag_addr[win];
         cur.wdata = ag_wd[win];
         cur.rdata = ag_wr[win] ? '0 : ref_mem[ag_addr[win]];
         if (ag_wr[win]) ref_mem[ag_addr[win]] = ag_wd[win];
         rr          = (win + 1) % N;
         ag_pend[win] = 1'b0;
      end
      in_rst = reset;
      for (int i = 0; i < N; i++)
         if (!ag_pend[i] && (rearm || (inj_pct > 0 && $urandom_range(99) < inj_pct)))
            post(i, 1'($urandom_range(1)), AW'($urandom_range(15)), $urandom);
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic wait_accept(input int i, input string tag);
      for (int n = 0; n < 40 && ag_pend[i]; n++) step();
      check(tag, ag_pend[i], 0);
   endtask

   initial begin
      reset = 1'b1;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      for (int a = 0; a < 256; a++) begin
         mem[a]     = $urandom;
         ref_mem[a] = mem[a];
      end
      for (int i = 0; i < N; i++) begin
         ag_pend[i] = 1'b0; ag_wr[i] = 1'b0; ag_addr[i] = '0; ag_wd[i] = '0;
      end
      cur = '0; have_txn = 1'b0; in_rst = 1'b1; rearm = 1'b0;
      t_acc = 0; rr = 0; k = 0; inj_pct = 0;

      // Both requesters held high through reset: strict alternation, 5 cycles apart.
      post(0, 1'b0, 8'h03, $urandom);
      post(1, 1'b0, 8'h04, $urandom);
      rearm = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) step();
      reset = 1'b0;
      repeat (22) step();
      rearm = 1'b0;
      repeat (20) step();
      check("rr_order0", (g_src.size() > 3) ? g_src[0] : -1, 0);
      check("rr_order1", (g_src.size() > 3) ? g_src[1] : -1, 1);
      check("rr_order2", (g_src.size() > 3) ? g_src[2] : -1, 0);
      check("rr_order3", (g_src.size() > 3) ? g_src[3] : -1, 1);
      check("rr_space1", (g_cyc.size() > 3) ? g_cyc[1] - g_cyc[0] : -1, L + 3);
      check("rr_space3", (g_cyc.size() > 3) ? g_cyc[3] - g_cyc[2] : -1, L + 3);

      // Single read of 0x10 by requester 0.
      mem[8'h10] = 32'hDEADBEEF;
      ref_mem[8'h10] = 32'hDEADBEEF;
      g_cyc.delete(); r_vec.delete(); r_dat.delete(); r_cyc.delete(); en_q.delete();
      post(0, 1'b0, 8'h10, $urandom);
      wait_accept(0, "rd_accept");
      ka = (g_cyc.size() > 0) ? g_cyc[0] : -100;
      repeat (6) step();
      check("rd_en_cycle",  (en_q.size() > 0)  ? en_q[0] - ka  : -1, 1);
      check("rd_resp_vec",  (r_vec.size() > 0) ? r_vec[0] : 'x, 2'b01);
      check("rd_resp_data", (r_dat.size() > 0) ? r_dat[0] : 'x, 32'hDEADBEEF);
      check("rd_resp_lat",  (r_cyc.size() > 0) ? r_cyc[0] - ka : -1, L + 2);

      // Write by requester 1, then read-back by requester 0.
      s_wr.delete(); s_src.delete(); r_vec.delete(); r_dat.delete();
      post(1, 1'b1, 8'h22, 32'hCAFE0001);
      wait_accept(1, "wr_accept");
      repeat (6) step();
      post(0, 1'b0, 8'h22, $urandom);
      wait_accept(0, "rb_accept");
      repeat (6) step();
      check("wr_snoop_write", (s_wr.size() > 1)  ? s_wr[0]  : 'x, 1);
      check("wr_snoop_src",   (s_src.size() > 1) ? s_src[0] : -1, 1);
      check("rb_snoop_write", (s_wr.size() > 1)  ? s_wr[1]  : 'x, 0);
      check("rb_snoop_src",   (s_src.size() > 1) ? s_src[1] : -1, 0);
      check("wr_resp_data",   (r_dat.size() > 1) ? r_dat[0] : 'x, 0);
      check("rb_resp_vec",    (r_vec.size() > 1) ? r_vec[1] : 'x, 2'b01);
      check("rb_resp_data",   (r_dat.size() > 1) ? r_dat[1] : 'x, 32'hCAFE0001);

      // Reset while waiting on memory: the read is dropped, requester 1 wins next.
      post(0, 1'b0, 8'h05, $urandom);
      wait_accept(0, "rst_accept");
      r_vec.delete();
      step();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      g_src.delete();
      post(1, 1'b0, 8'h07, $urandom);
      repeat (10) step();
      check("rst_resp_count", r_vec.size(), 1);
      check("rst_resp_vec",   (r_vec.size() > 0) ? r_vec[0] : 'x, 2'b10);
      check("rst_next_grant", (g_src.size() > 0) ? g_src[0] : -1, 1);

      // Idle bus for 20 cycles.
      en_q.delete(); s_wr.delete(); r_vec.delete();
      repeat (20) step();
      check("idle_mem_en",     en_q.size(),  0);
      check("idle_snoop",      s_wr.size(),  0);
      check("idle_resp_valid", r_vec.size(), 0);

      // Random traffic with occasional resets, then drain.
      inj_pct = 35;
      for (int n = 0; n < 500; n++) begin
         reset = ($urandom_range(99) == 0);
         step();
      end
      reset = 1'b0;
      inj_pct = 0;
      repeat (30) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
